dmem_lsu: RTL

Load/store unit sitting directly upstream of the word-only data memory (DATAMEM) in the MEM stage. It accepts one load/store request at a time from the EX/MEM pipeline register and validates the address. It performs byte, halfword and word accesses, using read-modify-write for sub-word stores, and returns formatted (sign/zero-extended) load data with a one-cycle response pulse. Byte ordering is big-endian: byte offset 0 maps to bits [31:24].

---
 rtl/dmem_lsu_pkg.sv | 20 ++
 rtl/dmem_lane_fmt.sv | 50 +++++
 rtl/dmem_lsu.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and defaults for the data-memory load/store unit.
// Imported by dmem_lsu and dmem_lane_fmt.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE,
        ST_RESP
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_2000;
    localparam int          DEF_DEPTH_WORDS = 512;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Big-endian lane handling: sub-word store merge and load extract/extend.
// Byte offset 0 is the most significant lane.
module dmem_lane_fmt
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [31:0] b_mask;
    logic [31:0] h_mask;
    logic [7:0]  b_val;
    logic [15:0] h_val;

    // ~offset equals 3-offset for a 2-bit lane index
    assign b_sh   = {~offset, 3'b000};
    assign h_sh   = {~offset[1], 4'b0000};
    assign b_mask = 32'h0000_00ff << b_sh;
    assign h_mask = 32'h0000_ffff << h_sh;
    assign b_val  = 8'(word >> b_sh);
    assign h_val  = 16'(word >> h_sh);

    always_comb begin
        merged = wdata;
        loaded = word;
        unique case (size)
            SZ_BYTE: begin
                merged = (word & ~b_mask)
                       | (32'(wdata[7:0]) << b_sh);
                loaded = sign_ext ? {{24{b_val[7]}}, b_val}
                                  : {24'h0, b_val};
            end
            SZ_HALF: begin
                merged = (word & ~h_mask)
                       | (32'(wdata[15:0]) << h_sh);
                loaded = sign_ext ? {{16{h_val[15]}}, h_val}
                                  : {16'h0, h_val};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit in front of the word-only DATAMEM.
// Sub-word stores are done as read-modify-write over two cycles.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_Addr_t,
    output logic [31:0] mem_Wdata,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_Rdata
);

    localparam logic [32:0] LIMIT =
        {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    state_t      state;
    state_t      state_nx;
    logic        r_we;
    logic        r_signed;
    logic        r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        accept;
    logic        req_err;
    logic [31:0] fmt_merged;
    logic [31:0] fmt_loaded;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        req_err = (req_size == SZ_BAD)
                | ((req_size == SZ_HALF) & req_addr[0])
                | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                | (req_addr < BASE_ADDR)
                | ({1'b0, req_addr} >= LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
        end else begin
            if (accept) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_err    <= req_err;
                r_size   <= req_size;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if ((state == ST_ACCESS) && mem_MemRead) begin
                r_word <= mem_Rdata;
            end
        end
    end

    // Memory side depends on state and latched request only
    always_comb begin
        state_nx     = state;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_Addr_t   = BASE_ADDR;
        mem_Wdata    = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_Addr_t = {r_addr[31:2], 2'b00};
                if (r_we && (r_size == SZ_WORD)) begin
                    mem_MemWrite = 1'b1;
                    mem_Wdata    = r_wdata;
                    state_nx     = ST_RESP;
                end else begin
                    mem_MemRead = 1'b1;
                    state_nx    = r_we ? ST_MERGE : ST_RESP;
                end
            end
            ST_MERGE: begin
                mem_Addr_t   = {r_addr[31:2], 2'b00};
                mem_MemWrite = 1'b1;
                mem_Wdata    = fmt_merged;
                state_nx     = ST_RESP;
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? fmt_loaded : '0;

    dmem_lane_fmt u_fmt (
        .size     (r_size),
        .offset   (r_addr[1:0]),
        .sign_ext (r_signed),
        .wdata    (r_wdata),
        .word     (r_word),
        .merged   (fmt_merged),
        .loaded   (fmt_loaded)
    );

endmodule
